// File: rtl/mdu_if.sv
// Multiply/divide unit bus: operation request, MTHI/MTLO writes and the HI/LO/busy/done view.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional MDU_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [AW-1:0]    acc, acc_nxt;
    logic [WIDTH-1:0] opnd, opnd_nxt;
    logic             is_div, is_div_nxt;
    logic             neg_lo, neg_lo_nxt;
    logic             neg_hi, neg_hi_nxt;
    logic             wb, wb_nxt;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    // Operand magnitudes and result signs for the request on the bus
    logic             sgn_rs, sgn_rt, start_ok;
    logic [WIDTH-1:0] mag_rs, mag_rt;

    assign sgn_rs   = !bus.op[0] && bus.rs_data[WIDTH-1];
    assign sgn_rt   = !bus.op[0] && bus.rt_data[WIDTH-1];
    assign mag_rs   = sgn_rs ? -bus.rs_data : bus.rs_data;
    assign mag_rt   = sgn_rt ? -bus.rt_data : bus.rt_data;
    assign start_ok = (state == IDLE) && !busy_r && bus.start;

    // One shift-add multiply step and one restoring divide step
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_step;
    logic [AW:0]      div_sh;
    logic [WIDTH:0]   div_diff;
    logic [AW-1:0]    div_step;
    logic             last, early_exit, early_zero;

    assign mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};
    assign div_sh   = {acc, 1'b0};
    assign div_diff = div_sh[AW:WIDTH] - {1'b0, opnd};
    assign div_step = div_diff[WIDTH] ? div_sh[AW-1:0]
                                      : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    assign last     = (cnt == CNT_W'(WIDTH - 1));

`ifdef MDU_EARLY_OUT_EN
    // Low rem_cnt bits of the stepped accumulator are the multiplier bits still to consume
    logic [CNT_W-1:0] rem_cnt;
    logic [WIDTH-1:0] low_mask;
    assign rem_cnt    = CNT_W'(WIDTH - 1) - cnt;
    assign low_mask   = (WIDTH'(1) << rem_cnt) - WIDTH'(1);
    assign early_exit = !is_div && ((mul_step[WIDTH-1:0] & low_mask) == '0);
    assign early_zero = !bus.op[1] && (mag_rt == '0);
`else
    assign early_exit = 1'b0;
    assign early_zero = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = early_zero ? FIX : CALC;
            CALC:    if (last || early_exit) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        opnd_nxt   = opnd;
        is_div_nxt = is_div;
        neg_lo_nxt = neg_lo;
        neg_hi_nxt = neg_hi;
        wb_nxt     = 1'b0;
        case (state)
            IDLE: if (start_ok) begin
                cnt_nxt    = '0;
                is_div_nxt = bus.op[1];
                opnd_nxt   = bus.op[1] ? mag_rt : mag_rs;
                acc_nxt    = bus.op[1] ? {{WIDTH{1'b0}}, mag_rs} : {{WIDTH{1'b0}}, mag_rt};
                // Divide by zero keeps the all-ones quotient unsigned
                neg_lo_nxt = (sgn_rs ^ sgn_rt) && (!bus.op[1] || (bus.rt_data != '0));
                neg_hi_nxt = sgn_rs;
            end
            CALC: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (is_div)          acc_nxt = div_step;
`ifdef MDU_EARLY_OUT_EN
                else if (early_exit) acc_nxt = mul_step >> rem_cnt;
`endif
                else                 acc_nxt = mul_step;
            end
            FIX: begin
                wb_nxt = 1'b1;
                if (is_div)
                    acc_nxt = {neg_hi ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH],
                               neg_lo ? -acc[WIDTH-1:0]  : acc[WIDTH-1:0]};
                else if (neg_lo)
                    acc_nxt = -acc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            wb     <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            opnd   <= opnd_nxt;
            is_div <= is_div_nxt;
            neg_lo <= neg_lo_nxt;
            neg_hi <= neg_hi_nxt;
            wb     <= wb_nxt;
        end
    end

    // Registered outputs: HI/LO write-back, MT writes only when idle and not starting
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            busy_r <= (state != IDLE);
            done_r <= wb;
            if (wb) begin
                hi_r <= acc[AW-1:WIDTH];
                lo_r <= acc[WIDTH-1:0];
            end else if ((state == IDLE) && !busy_r && !bus.start) begin
                if (bus.hi_we) hi_r <= bus.wr_data;
                if (bus.lo_we) lo_r <= bus.wr_data;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (latency expectations follow MDU_EARLY_OUT_EN).
module tb_mult_div_unit;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mdu_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] rt);
`ifdef MDU_EARLY_OUT_EN
        logic [31:0] m;
        int          n;
        if (op[1]) return 34;
        m = (op == 2'b00 && rt[31]) ? -rt : rt;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n + 2;
`else
        return 34;
`endif
    endfunction

    // extra: 1 = second start at cycle 5, 2 = MTHI while busy, 3 = MTHI together with start
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int extra);
        int          k;
        int          busy_cnt;
        logic        seen;
        logic [31:0] prev_hi;
        @(negedge clk);
        prev_hi     = bus.hi;
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = rs;
        bus.rt_data = rt;
        bus.hi_we   = (extra == 3);
        bus.wr_data = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        k = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            if (extra == 1 && k == 5) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.rs_data = 32'd50; bus.rt_data = 32'd5;
            end
            if (extra == 1 && k == 6) bus.start = 1'b0;
            if (extra == 2 && k == 1) begin
                bus.hi_we = 1'b1; bus.wr_data = 32'h5555_5555;
            end
            if (extra == 2 && k == 2) begin
                bus.hi_we = 1'b0;
                check({tag, " mthi_busy"}, 64'(bus.hi), 64'(prev_hi));
            end
            if (extra == 3 && k == 1) check({tag, " mthi_dropped"}, 64'(bus.hi), 64'(prev_hi));
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check({tag, " done"},    64'(seen),         64'(1));
        check({tag, " latency"}, 64'(k),            64'(exp_lat(op, rt)));
        check({tag, " busy"},    64'(busy_cnt),     64'(exp_lat(op, rt) - 1));
        check({tag, " hi"},      64'(bus.hi),       64'(exp_hi));
        check({tag, " lo"},      64'(bus.lo),       64'(exp_lo));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(bus.done),  64'(0));
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset hi",   64'(bus.hi),   64'(0));
        check("reset lo",   64'(bus.lo),   64'(0));

        run_op("mult_-3x7",   2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("divu_100_7",  2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1);
        run_op("div_-7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu_9_0",    2'b11, 32'd9,         32'd0,        32'd9,         32'hFFFF_FFFF, 0);
        run_op("div_-9_0",    2'b10, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF, 0);
        run_op("div_min_-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 0);

        // MTHI / MTLO in idle
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wr_data = 32'hABCD_0000;
        @(posedge clk);
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi hi",   64'(bus.hi),   64'(32'hABCD_0000));
        check("mthi done", 64'(bus.done), 64'(0));
        bus.lo_we = 1'b1; bus.wr_data = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo lo",   64'(bus.lo),   64'(32'h1234_5678));
        check("mtlo hi",   64'(bus.hi),   64'(32'hABCD_0000));
        check("mtlo done", 64'(bus.done), 64'(0));

        run_op("multu_1000x3", 2'b01, 32'd1000, 32'd3,         32'd0,         32'd3000,      2);
        run_op("mult_2x-4",    2'b00, 32'd2,    32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 3);
        run_op("multu_x0",     2'b01, 32'd77,   32'd0,         32'd0,         32'd0,         0);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd5; bus.rt_data = 32'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 64'(bus.busy), 64'(0));
        check("rst hi",   64'(bus.hi),   64'(0));
        check("rst lo",   64'(bus.lo),   64'(0));
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        check("rst no_done", 64'(dones), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
